// File: rtl/sd_dat_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sd_dat_pkg
// Purpose  : Shared constants for the SD DAT-line transmit path: FSM state
//            encodings, CRC-16 polynomial/initial value and line framing bits.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sd_dat_pkg;

  // Transmit FSM state encodings
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SBIT = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_CRC  = 3'd3;
  localparam logic [2:0] ST_EBIT = 3'd4;

  // CRC-CCITT x^16 + x^12 + x^5 + 1
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'h0000;

  // Line framing
  localparam logic START_BIT = 1'b0;
  localparam logic END_BIT   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sd_crc16_ser.sv
`default_nettype none
// ============================================================================
// Module   : sd_crc16_ser
// Purpose  : Bit-serial CRC-16 register with a plain shift-out mode so the
//            finished checksum can be driven onto the line MSB-first.
// Ports    : CLK       in   system clock
//            RST       in   asynchronous active-high reset
//            clr       in   synchronous clear to CRC_INIT
//            en        in   accumulate bitval into the CRC
//            bitval    in   data bit being transmitted
//            shift_out in   shift left with zero fill, no feedback
//            crc       out  current CRC register contents
// Revision : 1.0 - initial release
// ============================================================================
module sd_crc16_ser
  import sd_dat_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        clr,
  input  logic        en,
  input  logic        bitval,
  input  logic        shift_out,
  output logic [15:0] crc
);

  logic [15:0] r_crc;
  logic        w_inv;

  // Feedback term; XOR-ing the polynomial into the shifted value touches
  // exactly bits 0, 5 and 12.
  assign w_inv = bitval ^ r_crc[15];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_crc <= CRC_INIT;
    end else if (clr) begin
      r_crc <= CRC_INIT;
    end else if (en) begin
      r_crc <= {r_crc[14:0], 1'b0} ^ (w_inv ? CRC_POLY : 16'h0000);
    end else if (shift_out) begin
      r_crc <= {r_crc[14:0], 1'b0};
    end
  end

  assign crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/sd_dat_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sd_dat_tx_ctrl
// Purpose  : Sequences one SD data block on a single DAT line:
//            start bit, bytes MSB-first, CRC-16 MSB-first, end bit.
//            Advances only on SD bit-clock ticks.
// Ports    : CLK, RST            clock / async active-high reset
//            tick                SD bit strobe
//            start, abort        block control
//            blk_len[LEN_W-1:0]  block length in bytes
//            din[7:0], din_valid host byte stream
//            din_ready           byte consumed this cycle
//            sd_dat_o, sd_dat_oe DAT pad value / output enable
//            busy, done, err     status (done/err are one-cycle pulses)
// Revision : 1.0 - initial release
// ============================================================================
module sd_dat_tx_ctrl
  import sd_dat_pkg::*;
#(
  parameter int LEN_W = 12
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             tick,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] blk_len,
  input  logic [7:0]       din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sd_dat_o,
  output logic             sd_dat_oe,
  output logic             busy,
  output logic             done,
  output logic             err
);

  logic [2:0]       r_state;
  logic [7:0]       r_sreg;
  logic [2:0]       r_bitcnt;
  logic [LEN_W-1:0] r_bytes_left;   // bytes still to be loaded after current
  logic [3:0]       r_crccnt;

  logic        w_active;
  logic        w_abort;
  logic        w_accept;
  logic        w_zero_err;
  logic        w_load;
  logic        w_underrun;
  logic        w_crc_en;
  logic        w_crc_shift;
  logic [15:0] w_crc;

  assign w_active   = (r_state != ST_IDLE);
  assign w_abort    = abort & w_active;
  assign w_accept   = (r_state == ST_IDLE) & start & ~abort & (blk_len != '0);
  assign w_zero_err = (r_state == ST_IDLE) & start & ~abort & (blk_len == '0);

  // A byte must be fetched on the start-bit tick and on the last-bit tick of
  // every byte that is followed by another one.
  assign w_load = tick & ~w_abort &
                  ((r_state == ST_SBIT) |
                   ((r_state == ST_DATA) & (r_bitcnt == 3'd7) & (r_bytes_left != '0)));

  assign w_underrun  = w_load & ~din_valid;
  assign din_ready   = w_load & din_valid;
  assign err         = w_abort | w_underrun | w_zero_err;
  assign done        = (r_state == ST_EBIT) & tick & ~w_abort;
  assign busy        = w_active;
  assign sd_dat_oe   = w_active;
  assign w_crc_en    = (r_state == ST_DATA) & tick & ~w_abort;
  assign w_crc_shift = (r_state == ST_CRC) & tick & ~w_abort;

  always_comb begin
    sd_dat_o = END_BIT;
    case (r_state)
      ST_SBIT: sd_dat_o = START_BIT;
      ST_DATA: sd_dat_o = r_sreg[7];
      ST_CRC:  sd_dat_o = w_crc[15];
      ST_EBIT: sd_dat_o = END_BIT;
      default: sd_dat_o = END_BIT;
    endcase
  end

  sd_crc16_ser u_crc (
    .CLK       (CLK),
    .RST       (RST),
    .clr       (w_accept),
    .en        (w_crc_en),
    .bitval    (r_sreg[7]),
    .shift_out (w_crc_shift),
    .crc       (w_crc)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_sreg       <= 8'h00;
      r_bitcnt     <= 3'd0;
      r_bytes_left <= '0;
      r_crccnt     <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_bytes_left <= blk_len;
            r_state      <= ST_SBIT;
          end
        end
        ST_SBIT: begin
          if (w_abort) begin
            r_state <= ST_IDLE;
          end else if (tick) begin
            if (din_valid) begin
              r_sreg       <= din;
              r_bytes_left <= r_bytes_left - LEN_W'(1);
              r_bitcnt     <= 3'd0;
              r_state      <= ST_DATA;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (w_abort) begin
            r_state <= ST_IDLE;
          end else if (tick) begin
            r_bitcnt <= r_bitcnt + 3'd1;   // wraps 7 -> 0 per byte
            if (r_bitcnt == 3'd7) begin
              if (r_bytes_left != '0) begin
                if (din_valid) begin
                  r_sreg       <= din;
                  r_bytes_left <= r_bytes_left - LEN_W'(1);
                end else begin
                  r_state <= ST_IDLE;
                end
              end else begin
                r_crccnt <= 4'd0;
                r_state  <= ST_CRC;
              end
            end else begin
              r_sreg <= {r_sreg[6:0], 1'b0};
            end
          end
        end
        ST_CRC: begin
          if (w_abort) begin
            r_state <= ST_IDLE;
          end else if (tick) begin
            r_crccnt <= r_crccnt + 4'd1;
            if (r_crccnt == 4'd15) begin
              r_state <= ST_EBIT;
            end
          end
        end
        ST_EBIT: begin
          if (w_abort || tick) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/sd_dat_tx_ctrl.md
Name: sd_dat_tx_ctrl

Overview:
- Sequences one SD data-block transmission on a single DAT line.
- Framing, in order: start bit, byte stream MSB-first, 16-bit CRC-CCITT (x^16+x^12+x^5+1, init 0) MSB-first, end bit.
- Owns the serial CRC-16 datapath: clears it per block, enables it only for data bits, then shifts its contents onto the line.
- Sits between the host-side byte FIFO and the SD pad logic; advances only on SD bit-clock ticks.

Parameters:
- LEN_W, 12, width of block-length field in bytes (max block 2^LEN_W-1 bytes).

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-high reset
- tick  in  1  SD bit strobe; one line bit per cycle with tick=1
- start  in  1  pulse; begin a block (sampled only in IDLE)
- abort  in  1  level; terminate current block
- blk_len  in  LEN_W  block length in bytes, latched on accepted start
- din  in  8  next data byte
- din_valid  in  1  din holds a valid byte
- din_ready  out  1  byte consumed this cycle
- sd_dat_o  out  1  DAT line value
- sd_dat_oe  out  1  DAT output enable
- busy  out  1  block in progress
- done  out  1  one-cycle pulse, block completed normally
- err  out  1  one-cycle pulse: underrun, abort or zero-length start

Behaviour:
- Reset values: sd_dat_o=1, sd_dat_oe=0, busy=0, done=0, err=0, din_ready=0, CRC=0, state=IDLE.
- States: IDLE, SBIT, DATA, CRC, EBIT.
- IDLE:
  - start=1, blk_len!=0: latch blk_len, clear CRC register, go to SBIT, busy=1.
  - start=1, blk_len==0: err pulse, stay in IDLE.
  - Output stays sd_dat_o=1, oe=0.
- SBIT:
  - Drive sd_dat_o=0, oe=1.
  - On tick: if din_valid, load din into shift register, din_ready=1 for that cycle, go to DATA; otherwise underrun.
- DATA:
  - sd_dat_o = shift register MSB.
  - On each tick: CRC enable=1 with BITVAL = the bit currently driven, shift left, bit counter++.
  - On the tick of bit 0 of a byte: if bytes remain, require din_valid (load, din_ready=1), else go to CRC.
  - CRC is never enabled outside DATA ticks.
- CRC:
  - sd_dat_o = CRC[15].
  - On each tick: shift the CRC register left by 1, with no feedback. This is a separate shift-out mode of the CRC sub-module.
  - After 16 ticks, go to EBIT.
- EBIT:
  - sd_dat_o=1, oe=1.
  - On tick: done=1 for that cycle, go to IDLE, busy=0, oe=0.
- Timing:
  - Total line bits per block = 8*blk_len + 18.
  - First line bit (start bit) is visible the cycle after start is accepted.
- Underrun (din_valid=0 at a required load tick):
  - err pulse, go to IDLE same cycle, oe=0, sd_dat_o=1.
  - No byte is consumed.
- abort=1 in any non-IDLE state: same response as underrun, takes priority over tick.
- abort in IDLE: ignored. A start with abort=1 at the same cycle is not accepted.
- start while busy: ignored.
- done and err are never asserted together.
- tick=0: all state, counters, CRC and outputs hold.
- Byte counter: decrements per loaded byte.
  - blk_len = 2^LEN_W-1 must work with no wrap.
  - Bit counter wraps 7->0 per byte.
- RST mid-block: immediate return to reset values. The line is released (oe=0) asynchronously.

Decomposition:
- Package sd_dat_pkg: state enum (IDLE, SBIT, DATA, CRC, EBIT), CRC_POLY=16'h1021, CRC_INIT=16'h0000, START_BIT=1'b0, END_BIT=1'b1.
- One sub-module, sd_crc16_ser: serial CRC-16 register.
  - Inputs: CLK, RST, clr (synchronous), en, bitval, shift_out.
  - When en=1: CRC[0] <= bitval^CRC[15]; CRC[5] <= CRC[4]^inv; CRC[12] <= CRC[11]^inv; other bits shift up by one.
  - When shift_out=1: plain left shift, 0 in.
  - Output: crc[15:0].

Test Plan:
- blk_len=1, din=8'h00 always valid, tick every cycle -> line: 0, eight 0s, sixteen 0s (CRC 16'h0000), 1. Total 26 bits; done pulse on 26th tick; din_ready asserted exactly once.
- blk_len=512, all bytes 8'hFF -> CRC bits on line = 16'h7FA1 MSB-first; 4114 line bits; one done pulse; 512 din_ready pulses.
- blk_len=2, din_valid dropped at second-byte load tick -> err pulse that cycle, oe=0 next cycle, no done, one byte consumed.
- tick asserted every 4th cycle, blk_len=1, din=8'hFF -> each line bit held 4 cycles; same bit sequence as the tick-every-cycle case.
- abort raised during CRC state bit 5, then RST mid-DATA on a second block -> err pulse with IDLE outputs after the abort; immediate oe=0, busy=0 on RST.
- start with blk_len=0 -> err pulse, busy stays 0. A start during busy -> ignored; the block in progress is unaffected.
